// File: rtl/blk_61a6df.sv
// Virtual-JTAG scan host: walks UIR -> CDR -> SDR -> UDR -> RTI on a divided TCK to swap one DR word
// with the debug-module target. Define QYSYS_JTAG_SCAN_IR_CACHE_EN to skip UIR when the IR is unchanged.
module blk_61a6df #(
    parameter int TCK_DIV  = 2,
    parameter int SR_WIDTH = 38,
    parameter int RTI_TCKS = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [1:0]          vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int DW      = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int CNT_MAX = (SR_WIDTH > RTI_TCKS) ? SR_WIDTH : RTI_TCKS;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TCK_DIV - 1);
    localparam logic [CW-1:0] SR_LAST  = CW'(SR_WIDTH - 1);
    localparam logic [CW-1:0] RTI_LAST = CW'(RTI_TCKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI, ST_DONE
    } state_e;

    typedef struct packed {
        logic uir;
        logic cdr;
        logic sdr;
        logic udr;
        logic rti;
    } strobe_t;

    function automatic strobe_t strobe_of(input state_e s);
        strobe_t st;
        st = '0;
        case (s)
            ST_UIR:  st.uir = 1'b1;
            ST_CDR:  st.cdr = 1'b1;
            ST_SDR:  st.sdr = 1'b1;
            ST_UDR:  st.udr = 1'b1;
            ST_RTI:  st.rti = 1'b1;
            default: ;
        endcase
        return st;
    endfunction

    state_e              state_q;
    logic                start_q;
    logic                cmd_ready_q;
    logic [1:0]          ir_q;
    logic [1:0]          ir_in_q;
    logic [SR_WIDTH-1:0] sh_q;
    logic [SR_WIDTH-1:0] cap_q;
    logic [SR_WIDTH-1:0] rsp_data_q;
    logic                rsp_valid_q;
    logic                tck_q;
    logic                tdi_q;
    strobe_t             strobe_q;
    logic [DW-1:0]       div_q;
    logic [CW-1:0]       bit_q;

    logic timed;
    logic half_end;
    logic tck_rise;
    logic period_end;
    logic accept;
    logic cache_hit;

    assign timed      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign half_end   = (div_q == DIV_LAST);
    assign tck_rise   = half_end && !tck_q;
    assign period_end = half_end && tck_q;
    assign accept     = cmd_valid && cmd_ready_q;

`ifdef QYSYS_JTAG_SCAN_IR_CACHE_EN
    logic ir_vld_q;
    // The IR currently on vji_ir_in is by construction the last one shifted through UIR.
    assign cache_hit = ir_vld_q && (ir_q == ir_in_q);
`else
    assign cache_hit = 1'b0;
`endif

    // NOTE: every register in this block is assigned with <= so all next-state terms read the
    // pre-edge values; a blocking assignment here would let later statements see updated state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            ir_q        <= '0;
            ir_in_q     <= '0;
            sh_q        <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            strobe_q    <= '0;
            div_q       <= '0;
            bit_q       <= '0;
`ifdef QYSYS_JTAG_SCAN_IR_CACHE_EN
            ir_vld_q    <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;

            if (timed) begin
                if (half_end) begin
                    div_q <= '0;
                    tck_q <= ~tck_q;
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    // One setup cycle after acceptance aligns the completion pulse with the
                    // documented latency while TCK is still parked low.
                    if (start_q) begin
                        start_q <= 1'b0;
                        if (cache_hit) begin
                            state_q  <= ST_CDR;
                            strobe_q <= strobe_of(ST_CDR);
                        end else begin
                            state_q  <= ST_UIR;
                            strobe_q <= strobe_of(ST_UIR);
                            ir_in_q  <= ir_q;
`ifdef QYSYS_JTAG_SCAN_IR_CACHE_EN
                            ir_vld_q <= 1'b1;
`endif
                        end
                    end else if (accept) begin
                        start_q     <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        ir_q        <= cmd_ir;
                        sh_q        <= cmd_data;
                    end
                end

                ST_UIR: begin
                    if (period_end) begin
                        state_q  <= ST_CDR;
                        strobe_q <= strobe_of(ST_CDR);
                    end
                end

                ST_CDR: begin
                    if (period_end) begin
                        state_q  <= ST_SDR;
                        strobe_q <= strobe_of(ST_SDR);
                        bit_q    <= '0;
                        tdi_q    <= sh_q[0];
                        sh_q     <= sh_q >> 1;
                    end
                end

                ST_SDR: begin
                    if (tck_rise) begin
                        cap_q <= {vji_tdo, cap_q[SR_WIDTH-1:1]};
                    end
                    if (period_end) begin
                        if (bit_q == SR_LAST) begin
                            state_q  <= ST_UDR;
                            strobe_q <= strobe_of(ST_UDR);
                            tdi_q    <= 1'b0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tdi_q <= sh_q[0];
                            sh_q  <= sh_q >> 1;
                        end
                    end
                end

                ST_UDR: begin
                    if (period_end) begin
                        state_q  <= ST_RTI;
                        strobe_q <= strobe_of(ST_RTI);
                        bit_q    <= '0;
                    end
                end

                ST_RTI: begin
                    if (period_end) begin
                        if (bit_q == RTI_LAST) begin
                            state_q     <= ST_DONE;
                            strobe_q    <= '0;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= cap_q;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end

                default: begin
                    state_q  <= ST_IDLE;
                    strobe_q <= '0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign vji_tck   = tck_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_in_q;
    assign vji_uir   = strobe_q.uir;
    assign vji_cdr   = strobe_q.cdr;
    assign vji_sdr   = strobe_q.sdr;
    assign vji_udr   = strobe_q.udr;
    assign vji_rti   = strobe_q.rti;

endmodule

// File: tb/tb_blk_61a6df.sv
// Bench for blk_61a6df: a behavioural JTAG target swaps DR contents with the host; a second
// instance exercises a short, fast-TCK configuration with TDO tied high.
module tb_blk_61a6df;

    localparam int W  = 38;
    localparam int D  = 2;
    localparam int R  = 1;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic         cmd_valid, cmd_ready, rsp_valid;
    logic [1:0]   cmd_ir, vji_ir_in;
    logic [W-1:0] cmd_data, rsp_data;
    logic         vji_tck, vji_tdi, vji_tdo;
    logic         vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    logic          s_valid, s_ready, s_rsp_valid;
    logic [1:0]    s_ir, s_ir_in;
    logic [SW-1:0] s_data, s_rsp_data;
    logic          s_tck, s_tdi, s_tdo;
    logic          s_uir, s_cdr, s_sdr, s_udr, s_rti;

    blk_61a6df u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    blk_61a6df #(.TCK_DIV(1), .SR_WIDTH(SW), .RTI_TCKS(1)) u_small (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(s_valid), .cmd_ready(s_ready), .cmd_ir(s_ir), .cmd_data(s_data),
        .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data),
        .vji_tck(s_tck), .vji_tdi(s_tdi), .vji_tdo(s_tdo), .vji_ir_in(s_ir_in),
        .vji_uir(s_uir), .vji_cdr(s_cdr), .vji_sdr(s_sdr), .vji_udr(s_udr), .vji_rti(s_rti)
    );
    assign s_tdo = 1'b1;

    // Target DR: shifts TDI in at TCK rise during SDR; outside SDR TDO carries random noise.
    logic [W-1:0] tgt;
    logic         noise;
    assign vji_tdo = vji_sdr ? tgt[0] : noise;
    always @(negedge clk) noise <= 1'($urandom);

    int   tck_rises, sdr_rises, onehot_viol, rsp_cnt;
    logic uir_seen;
    logic [1:0] ir_at_uir;
    logic tdi_log[$];

    always @(posedge vji_tck) begin
        tck_rises++;
        if (vji_sdr) begin
            sdr_rises++;
            tdi_log.push_back(vji_tdi);
            tgt <= {vji_tdi, tgt[W-1:1]};
        end
    end

    always @(negedge clk) begin
        if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) onehot_viol++;
        if (vji_uir) begin
            uir_seen  = 1'b1;
            ir_at_uir = vji_ir_in;
        end
        if (rsp_valid) rsp_cnt++;
    end

    int   s_tck_rises;
    logic s_tdi_log[$];
    always @(posedge s_tck) begin
        s_tck_rises++;
        if (s_sdr) s_tdi_log.push_back(s_tdi);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model of the IR cache: last IR of a completed command, cleared by reset.
    bit         m_vld = 1'b0;
    logic [1:0] m_ir  = 2'b00;

    task automatic do_cmd(input string tag, input logic [1:0] ir, input logic [W-1:0] data,
                          input logic [W-1:0] pre, input logic [W-1:0] exp_rsp,
                          input logic [W-1:0] exp_tgt, input bit hold);
        bit           hit;
        int           exp_lat, exp_tck, lat, waits;
        logic [W-1:0] packed_tdi;
`ifdef QYSYS_JTAG_SCAN_IR_CACHE_EN
        hit = m_vld && (m_ir == ir);
`else
        hit = 1'b0;
`endif
        exp_lat = 2 * D * (W + 3 + R) + 1 - (hit ? 2 * D : 0);
        exp_tck = W + 3 + R - (hit ? 1 : 0);

        @(negedge clk);
        cmd_ir    = ir;
        cmd_data  = data;
        cmd_valid = 1'b1;
        tgt      <= pre;
        waits     = 0;
        while (cmd_ready !== 1'b1 && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        check({tag, "_accepted"}, waits < 1000, 1);
        tck_rises = 0; sdr_rises = 0; onehot_viol = 0; rsp_cnt = 0;
        uir_seen = 1'b0; ir_at_uir = 2'b00;
        tdi_log.delete();

        @(posedge clk);
        #1;
        if (hold) begin
            cmd_data = ~data;
            cmd_ir   = ~ir;
        end else begin
            cmd_valid = 1'b0;
        end
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (rsp_valid !== 1'b1 && lat < 2000);

        packed_tdi = '0;
        foreach (tdi_log[i]) if (i < W) packed_tdi[i] = tdi_log[i];
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_rsp_data"}, rsp_data, exp_rsp);
        check({tag, "_target"}, tgt, exp_tgt);
        check({tag, "_tdi_seq"}, packed_tdi, exp_tgt);
        check({tag, "_tck_rises"}, tck_rises, exp_tck);
        check({tag, "_sdr_rises"}, sdr_rises, W);
        check({tag, "_uir_seen"}, uir_seen, !hit);
        if (!hit) check({tag, "_ir_in"}, ir_at_uir, ir);
        check({tag, "_onehot"}, onehot_viol, 0);
        check({tag, "_busy_at_rsp"}, cmd_ready, 0);
        m_vld = 1'b1;
        m_ir  = ir;

        @(posedge clk);
        #1;
        check({tag, "_rsp_pulse"}, {rsp_valid, rsp_cnt[1:0]}, {1'b0, 2'd1});
        check({tag, "_ready_after"}, cmd_ready, 1);
    endtask

    task automatic small_cmd(input string tag, input logic [1:0] ir, input logic [SW-1:0] data);
        int            lat, waits;
        logic [SW-1:0] packed_tdi;
        @(negedge clk);
        s_ir = ir; s_data = data; s_valid = 1'b1;
        waits = 0;
        while (s_ready !== 1'b1 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        check({tag, "_accepted"}, waits < 100, 1);
        s_tck_rises = 0;
        s_tdi_log.delete();
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (s_rsp_valid !== 1'b1 && lat < 200);
        packed_tdi = '0;
        foreach (s_tdi_log[i]) if (i < SW) packed_tdi[i] = s_tdi_log[i];
        check({tag, "_latency"}, lat, 2 * 1 * (SW + 3 + 1) + 1);
        check({tag, "_rsp_data"}, s_rsp_data, {SW{1'b1}});
        check({tag, "_tdi_count"}, s_tdi_log.size(), SW);
        check({tag, "_tdi_seq"}, packed_tdi, data);
        check({tag, "_tck_rises"}, s_tck_rises, SW + 3 + 1);
    endtask

    typedef struct {
        logic [1:0]   ir;
        logic [W-1:0] data;
        logic [W-1:0] pre;
        bit           hold;
        logic [W-1:0] exp_rsp;
        logic [W-1:0] exp_tgt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int waits;
        tbl[0] = '{2'b01, 38'h2A_5555_AAAA, 38'h15_0F0F_F0F0, 1'b0, 38'h15_0F0F_F0F0, 38'h2A_5555_AAAA};
        tbl[1] = '{2'b00, 38'h3F_FFFF_FFFF, 38'h00_0000_0001, 1'b0, 38'h00_0000_0001, 38'h3F_FFFF_FFFF};
        tbl[2] = '{2'b00, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 1'b0, 38'h3F_FFFF_FFFF, 38'h00_0000_0000};
        tbl[3] = '{2'b11, 38'h20_0000_0001, 38'h12_3456_789A, 1'b1, 38'h12_3456_789A, 38'h20_0000_0001};
        tbl[4] = '{2'b11, 38'h0F_EDCB_A987, 38'h2B_ADC0_FFEE, 1'b0, 38'h2B_ADC0_FFEE, 38'h0F_EDCB_A987};

        cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_data = '0;
        s_valid = 1'b0; s_ir = 2'b00; s_data = '0;
        tck_rises = 0; sdr_rises = 0; onehot_viol = 0; rsp_cnt = 0; s_tck_rises = 0;
        uir_seen = 1'b0; ir_at_uir = 2'b00;

        repeat (3) @(negedge clk);
        check("rst_outputs", {rsp_valid, vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr,
                              vji_udr, vji_rti}, '0);
        check("rst_rsp_data", rsp_data, '0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", cmd_ready, 1);

        foreach (tbl[i]) do_cmd($sformatf("vec%0d", i), tbl[i].ir, tbl[i].data, tbl[i].pre,
                                 tbl[i].exp_rsp, tbl[i].exp_tgt, tbl[i].hold);

        for (int i = 0; i < 6; i++) begin
            logic [1:0]   ir;
            logic [W-1:0] d, p;
            ir = 2'($urandom);
            d  = W'({$urandom, $urandom});
            p  = W'({$urandom, $urandom});
            do_cmd($sformatf("rnd%0d", i), ir, d, p, p, d, 1'b0);
        end

        // Abort a scan part-way through SDR with an asynchronous reset.
        @(negedge clk);
        cmd_ir = 2'b11; cmd_data = '1; cmd_valid = 1'b1;
        tgt <= '0;
        waits = 0;
        while (cmd_ready !== 1'b1 && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        sdr_rises = 0;
        rsp_cnt = 0;
        waits = 0;
        while (sdr_rises < 10 && waits < 2000) begin
            @(negedge clk);
            waits++;
        end
        check("abort_reach_sdr", {vji_sdr, 8'(sdr_rises)}, {1'b1, 8'd10});
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {rsp_valid, vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr,
                                vji_udr, vji_rti}, '0);
        check("abort_rsp_data", rsp_data, '0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_vld = 1'b0;
        repeat (200) @(negedge clk);
        check("abort_no_rsp", rsp_cnt, 0);
        check("abort_ready", cmd_ready, 1);
        do_cmd("post_rst", 2'b10, 38'h31_2345_6789, 38'h0A_BCDE_F012, 38'h0A_BCDE_F012,
               38'h31_2345_6789, 1'b0);

        small_cmd("small_1001", 2'b00, 4'b1001);
        small_cmd("small_rnd", 2'b11, 4'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/blk_61a6df.md
QYSYS_TEST_NIOS2_QSYS_0_JTAG_DEBUG_MODULE_SCAN_HOST -- requirements
Module: qysys_test_nios2_qsys_0_jtag_debug_module_scan_host

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2: TCK half-period in clk cycles (>=1).
REQ-002 SHALL have parameter SR_WIDTH, default 38: DR scan length in bits.
REQ-003 SHALL have parameter RTI_TCKS, default 1: number of TCK periods spent in run-test-idle after update.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk input 1 (system clock, all logic on rising edge); reset_n input 1 (async assert, active low).
REQ-005 SHALL have these command ports: cmd_valid in 1 (command request); cmd_ready out 1 (idle, can accept); cmd_ir in 2 (virtual IR value); cmd_data in SR_WIDTH (DR shift-in data).
REQ-006 SHALL have these response ports: rsp_valid out 1 (one-cycle completion pulse); rsp_data out SR_WIDTH (captured DR shift-out data).
REQ-007 SHALL drive these virtual-JTAG ports toward the debug-module target: vji_tck out 1; vji_tdi out 1; vji_tdo in 1; vji_ir_in out 2; vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti out 1 each.

Function
REQ-008 SHALL accept a command when cmd_valid && cmd_ready on a clk edge, latching cmd_ir and cmd_data; cmd_ready SHALL be high only in IDLE.
REQ-009 SHALL implement FSM IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> DONE -> IDLE.
REQ-010 Each non-IDLE, non-DONE state SHALL span whole TCK periods: vji_tck low for TCK_DIV clk cycles, then high for TCK_DIV cycles. State and strobe changes SHALL occur only at TCK falling edges (period boundaries).
REQ-011 SHALL hold vji_tck low in IDLE and DONE.
REQ-012 Durations: UIR 1 period; CDR 1 period; SDR SR_WIDTH periods; UDR 1 period; RTI RTI_TCKS periods; DONE 1 clk cycle.
REQ-013 vji_uir, vji_cdr, vji_sdr, vji_udr and vji_rti SHALL each be high exactly while in its matching state; at most one SHALL be high at a time.
REQ-014 vji_ir_in SHALL take the latched cmd_ir at entry to UIR and hold it until the next UIR.
REQ-015 In SDR, vji_tdi SHALL present the shift register LSB first. Each shift SHALL occur at a TCK falling edge, with bit 0 valid for the first SDR period.
REQ-016 vji_tdo SHALL be sampled on the clk cycle in which vji_tck rises during SDR. The sample SHALL be shifted into the MSB of the capture register (shift right). After SR_WIDTH samples, the first-sampled bit SHALL be at bit 0.
REQ-017 rsp_data SHALL update in DONE and hold until the next DONE; rsp_valid SHALL be high for exactly the DONE cycle. There is no backpressure.
REQ-018 Latency: rsp_valid SHALL assert 2*TCK_DIV*(SR_WIDTH+3+RTI_TCKS)+1 clk cycles after the accepting edge (169 at defaults).
REQ-019 cmd_valid while busy SHALL be ignored, with no latching and no effect on the scan in progress.
REQ-020 vji_tdo SHALL be ignored outside SDR rising-edge sample points.

Reset
REQ-021 While reset_n is low, SHALL force: state IDLE; cmd_ready 1 after release; rsp_valid 0; rsp_data 0; vji_tck 0; vji_tdi 0; vji_ir_in 0; all strobes 0; IR-cache valid flag 0.
REQ-022 Reset asserted mid-scan SHALL abort immediately with no rsp_valid; the first command after release SHALL perform a full sequence.

Configuration
REQ-023 Macro QYSYS_JTAG_SCAN_IR_CACHE_EN SHALL control IR caching.
REQ-024 With the macro defined, SHALL record the last IR shifted and a valid flag. If a new cmd_ir equals the cached IR and the flag is set, SHALL skip UIR and go IDLE -> CDR, reducing latency by 2*TCK_DIV cycles.
REQ-025 With the macro undefined, every command SHALL traverse UIR, and no cache state SHALL exist.

Verification
REQ-026 Defaults, cmd_ir=2'b01, cmd_data=38'h2A_5555_AAAA, vji_tdo looped from a 38-bit target register preloaded 38'h15_0F0F_F0F0 -> target receives 38'h2A_5555_AAAA; rsp_data=38'h15_0F0F_F0F0; rsp_valid at cycle 169.
REQ-027 Defaults -> exactly 42 vji_tck rising edges per command; vji_sdr high for 38 of them; only one strobe high at any clk.
REQ-028 cmd_valid held high continuously -> second command accepted only on the cycle after rsp_valid; a cmd_data change during the busy period does not appear on vji_tdi.
REQ-029 reset_n pulsed low at SDR bit 10 -> all outputs at reset values within the same cycle; no rsp_valid; next command, with cmd_ir=2'b10, shows the UIR strobe.
REQ-030 QYSYS_JTAG_SCAN_IR_CACHE_EN defined, two commands with cmd_ir=2'b00 -> first latency 169, second 165 with no vji_uir; a third with cmd_ir=2'b11 -> latency 169.
REQ-031 TCK_DIV=1, SR_WIDTH=4, cmd_data=4'b1001, vji_tdo tied 1 -> vji_tdi sequence 1,0,0,1; rsp_data=4'hF; latency 17.
